// File: rtl/uart_ascii_pkg.sv
// Shared FSM state encoding and ASCII constants for the UART hex word sender.
// Imported by the sequencer and its nibble-to-ASCII converter.
package uart_ascii_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PFX0  = 3'd1,
    PFX1  = 3'd2,
    DIGIT = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5
  } state_t;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_X  = 8'h78;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_A  = 8'h41;

endpackage

// File: rtl/uart_hex_word_sender_hex_to_ascii.sv
// Combinational nibble-to-ASCII converter (HEX_To_ASCII).
// Produces uppercase hex characters: 0..9 -> 8'h30..8'h39, A..F -> 8'h41..8'h46.
module uart_hex_word_sender_hex_to_ascii
  import uart_ascii_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASC_0;
    if (nibble < 4'd10) begin
      ascii = ASC_0 + {4'h0, nibble};
    end else begin
      ascii = ASC_A + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/uart_hex_word_sender.sv
// Sends a captured binary word to a UART TX byte interface as ASCII hex text,
// optionally framed by a "0x" prefix and a CR LF terminator.
module uart_hex_word_sender
  import uart_ascii_pkg::*;
#(
  parameter int NIBBLES     = 8,
  parameter bit SEND_PREFIX = 1'b1,
  parameter bit SEND_CRLF   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NIBBLES - 1);

  state_t         state_reg, state_next;
  logic [W-1:0]   shift_reg, shift_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [7:0]     tx_data_reg, tx_data_next;
  logic           tx_valid_reg;
  logic           busy_reg;
  logic           done_reg;
  logic [7:0]     digit_ascii;
  logic           transfer;

  assign transfer = tx_valid_reg & tx_ready;

  // The byte register is loaded with what the *next* state will present, so the
  // converter looks at the top nibble of the shift register as it will be then.
  uart_hex_word_sender_hex_to_ascii u_hex_to_ascii (
    .nibble (shift_next[W-1 -: 4]),
    .ascii  (digit_ascii)
  );

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next = data_in;
          cnt_next   = '0;
          state_next = SEND_PREFIX ? PFX0 : DIGIT;
        end
      end
      PFX0: if (transfer) state_next = PFX1;
      PFX1: if (transfer) state_next = DIGIT;
      DIGIT: begin
        if (transfer) begin
          shift_next = shift_reg << 4;
          cnt_next   = cnt_reg + CW'(1);
          if (cnt_reg == LAST_DIGIT) begin
            cnt_next   = '0;
            state_next = SEND_CRLF ? CR : IDLE;
          end
        end
      end
      CR: if (transfer) state_next = LF;
      LF: if (transfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_data_next = 8'h00;
    unique case (state_next)
      IDLE:    tx_data_next = 8'h00;
      PFX0:    tx_data_next = ASC_0;
      PFX1:    tx_data_next = ASC_X;
      DIGIT:   tx_data_next = digit_ascii;
      CR:      tx_data_next = ASC_CR;
      LF:      tx_data_next = ASC_LF;
      default: tx_data_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      cnt_reg      <= '0;
      tx_data_reg  <= 8'h00;
      tx_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      cnt_reg      <= cnt_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= (state_next != IDLE);
      busy_reg     <= (state_next != IDLE);
      done_reg     <= (state_reg != IDLE) && (state_next == IDLE);
    end
  end

  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_uart_hex_word_sender.sv
// Self-checking bench for uart_hex_word_sender: four configurations, table vectors,
// hand-written reset/back-to-back sequences and randomized frames against a text model.
module tb_uart_hex_word_sender;

  localparam int M_RAND  = 1;
  localparam int M_PAT   = 2;
  localparam int M_NOISE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] din = '0;
  logic        start    [4];
  logic        tx_ready [4];
  logic [7:0]  tx_data  [4];
  logic        tx_valid [4];
  logic        busy     [4];
  logic        done     [4];

  int nib_cfg [4] = '{8, 2, 1, 16};
  bit pfx_cfg [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit crlf_cfg[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  int vecs = 0;
  int errs = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    int          id;
    logic [63:0] data;
    int          mode;
    string       exp_s;
  } vec_t;

  vec_t vt[6];

  always #5 clk = ~clk;

  uart_hex_word_sender #(.NIBBLES(8), .SEND_PREFIX(1'b1), .SEND_CRLF(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .data_in(din[31:0]), .busy(busy[0]),
    .done(done[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]));
  uart_hex_word_sender #(.NIBBLES(2), .SEND_PREFIX(1'b0), .SEND_CRLF(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .data_in(din[7:0]), .busy(busy[1]),
    .done(done[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]));
  uart_hex_word_sender #(.NIBBLES(1), .SEND_PREFIX(1'b0), .SEND_CRLF(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .data_in(din[3:0]), .busy(busy[2]),
    .done(done[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]));
  uart_hex_word_sender #(.NIBBLES(16), .SEND_PREFIX(1'b1), .SEND_CRLF(1'b1)) u3 (
    .clk(clk), .rst(rst), .start(start[3]), .data_in(din), .busy(busy[3]),
    .done(done[3]), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected text of one frame: prefix, hex digits MSB-first, terminator.
  task automatic build_model(input int id, input logic [63:0] data);
    int nv;
    exp_q.delete();
    if (pfx_cfg[id]) begin
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h78);
    end
    for (int k = nib_cfg[id] - 1; k >= 0; k--) begin
      nv = int'((data >> (4 * k)) & 64'hF);
      exp_q.push_back(nv < 10 ? 8'(48 + nv) : 8'(55 + nv));
    end
    if (crlf_cfg[id]) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic load_string(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or on timeout).
  task automatic run_frame(input int id, input logic [63:0] data, input int mode,
                           input string exp_s);
    logic [7:0] got[$];
    logic [7:0] held;
    bit         stalled = 1'b0;
    bit         seen_done = 1'b0;
    bit         ready;
    int         last_x = -1;
    if (exp_s.len() > 0) load_string(exp_s);
    else build_model(id, data);
    check("idle_busy", busy[id], 1'b0);
    din = data;
    start[id] = 1'b1;
    @(negedge clk);
    start[id] = 1'b0;
    check("first_busy", busy[id], 1'b1);
    for (int k = 0; k < 300 && !seen_done; k++) begin
      if (done[id]) begin
        seen_done = 1'b1;
        start[id] = 1'b0;
        check("done_timing", k, last_x + 1);
        check("done_busy", busy[id], 1'b0);
        check("done_valid", tx_valid[id], 1'b0);
      end else begin
        check("frame_valid", tx_valid[id], 1'b1);
        if (stalled) check("hold_data", tx_data[id], held);
        if ((mode & M_PAT) != 0) ready = (k % 4 == 0) || (k % 4 == 3);
        else if ((mode & M_RAND) != 0) ready = 1'($urandom_range(0, 1));
        else ready = 1'b1;
        tx_ready[id] = ready;
        if ((mode & M_NOISE) != 0) begin
          start[id] = 1'($urandom_range(0, 1));
          din = {$urandom, $urandom};
        end
        if (tx_valid[id] && ready) begin
          got.push_back(tx_data[id]);
          last_x = k;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = tx_data[id];
        end
        @(negedge clk);
      end
    end
    start[id] = 1'b0;
    tx_ready[id] = 1'b1;
    if (!seen_done) check("done_timeout", 0, 1);
    check("frame_len", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("byte%0d", i), got[i], exp_q[i]);
    $display("frame id=%0d data=%0h bytes=%0d expected=%0d", id, data, got.size(), exp_q.size());
  endtask

  initial begin
    int id;
    logic [63:0] rd;
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0;
      tx_ready[i] = 1'b1;
    end
    vt[0] = '{0, 64'hDEADBEEF, 0, "0xDEADBEEF\r\n"};
    vt[1] = '{1, 64'h9A, M_PAT, "9A"};
    vt[2] = '{2, 64'h0, 0, "0"};
    vt[3] = '{3, 64'h0123456789ABCDEF, 0, "0x0123456789ABCDEF\r\n"};
    vt[4] = '{0, 64'h0000000F, M_RAND, "0x0000000F\r\n"};
    vt[5] = '{1, 64'hF0, M_RAND | M_NOISE, "F0"};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("rst_busy", busy[i], 1'b0);
      check("rst_done", done[i], 1'b0);
      check("rst_valid", tx_valid[i], 1'b0);
      check("rst_data", tx_data[i], 8'h00);
    end
    rst = 1'b0;
    @(negedge clk);

    // tx_ready toggling while idle must not start anything
    for (int k = 0; k < 4; k++) begin
      tx_ready[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_valid", tx_valid[0], 1'b0);
    end
    tx_ready[0] = 1'b1;

    for (int v = 0; v < 6; v++) begin
      run_frame(vt[v].id, vt[v].data, vt[v].mode, vt[v].exp_s);
      @(negedge clk);
    end

    // start pulses while busy are ignored; start in the done cycle chains a frame
    run_frame(0, 64'h12345678, M_NOISE, "0x12345678\r\n");
    run_frame(0, 64'hCAFEF00D, 0, "0xCAFEF00D\r\n");
    @(negedge clk);

    // reset after five transfers, together with a start; rst must win
    din = 64'hA5A5A5A5;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    build_model(0, 64'hA5A5A5A5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("pre_rst_byte%0d", k), tx_data[0], exp_q[k]);
      @(negedge clk);
    end
    rst = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    check("abort_valid", tx_valid[0], 1'b0);
    check("abort_busy", busy[0], 1'b0);
    check("abort_done", done[0], 1'b0);
    rst = 1'b0;
    start[0] = 1'b0;
    @(negedge clk);
    check("post_rst_idle", busy[0], 1'b0);
    run_frame(0, 64'h0BADC0DE, 0, "0x0BADC0DE\r\n");
    @(negedge clk);

    for (int r = 0; r < 40; r++) begin
      id = int'($urandom_range(0, 3));
      rd = {$urandom, $urandom};
      run_frame(id, rd, int'($urandom_range(0, 1)) | (int'($urandom_range(0, 1)) * M_NOISE), "");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
